// File: rtl/imem_uart_loader_if.sv
// Bus between the UART program loader and the instruction memory / CPU reset.
// The master side is the loader; the slave side is the board, memory and host line.
interface imem_uart_loader_if #(
  parameter int ADDR_W = 5
);
  logic              rx;
  logic              load_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic [ADDR_W:0]   word_cnt;
  logic              full;
  logic              frame_err;

  modport master (
    input  rx, load_en,
    output mem_we, mem_addr, mem_wdata, cpu_rst, word_cnt, full, frame_err
  );

  modport slave (
    output rx, load_en,
    input  mem_we, mem_addr, mem_wdata, cpu_rst, word_cnt, full, frame_err
  );
endinterface

// File: rtl/imem_uart_loader.sv
// Serial program loader: receives 8N1 bytes, packs them little-endian into words
// and writes them to instruction memory while holding the CPU in reset.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  imem_uart_loader_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WCNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic              rxMeta_q, rxS_q, loadMeta_q, loadS_q, loadPrev_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       word_q, word_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic              full_q, full_d;
  logic              frameErr_q, frameErr_d;
  logic              loadRise, loadFall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q   <= 1'b1;
      rxS_q      <= 1'b1;
      loadMeta_q <= 1'b0;
      loadS_q    <= 1'b0;
      loadPrev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      byteIdx_q  <= '0;
      word_q     <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      wordCnt_q  <= '0;
      full_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxMeta_q   <= bus.rx;
      rxS_q      <= rxMeta_q;
      loadMeta_q <= bus.load_en;
      loadS_q    <= loadMeta_q;
      loadPrev_q <= loadS_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      byteIdx_q  <= byteIdx_d;
      word_q     <= word_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      wordCnt_q  <= wordCnt_d;
      full_q     <= full_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    byteIdx_d  = byteIdx_q;
    word_d     = word_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    wordCnt_d  = wordCnt_q;
    full_d     = full_q;
    frameErr_d = frameErr_q;
    loadRise   = loadS_q & ~loadPrev_q;
    loadFall   = ~loadS_q & loadPrev_q;

    case (state_q)
      IDLE: begin
        if (!rxS_q && loadS_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxS_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rxS_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) state_d = STOP;
          else bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!rxS_q) begin
            frameErr_d = 1'b1;
          end else begin
            byteIdx_d = byteIdx_q + 2'd1;
            case (byteIdx_q)
              2'd0: word_d[7:0]   = shift_q;
              2'd1: word_d[15:8]  = shift_q;
              2'd2: word_d[23:16] = shift_q;
              default: begin
                // Once full, the write register keeps the last word written.
                if (!full_q) begin
                  memWdata_d = {shift_q, word_q};
                  memWe_d    = 1'b1;
                end
              end
            endcase
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (memWe_q) begin
      wordCnt_d = wordCnt_q + WCNT_ONE;
      if (memAddr_q == ADDR_MAX) full_d = 1'b1;
      else memAddr_d = memAddr_q + ADDR_ONE;
    end

    // Leaving load mode abandons any byte in flight and beats a same-cycle word completion.
    if (loadFall) begin
      state_d   = IDLE;
      byteIdx_d = '0;
      word_d    = '0;
      memWe_d   = 1'b0;
    end

    if (loadRise) begin
      wordCnt_d  = '0;
      memAddr_d  = '0;
      byteIdx_d  = '0;
      word_d     = '0;
      full_d     = 1'b0;
      frameErr_d = 1'b0;
    end
  end

  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.cpu_rst   = rst | loadS_q;
  assign bus.word_cnt  = wordCnt_q;
  assign bus.full      = full_q;
  assign bus.frame_err = frameErr_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: fixed word vectors, framing corner cases and
// randomized load sessions against a queue-based model of the loader.
module tb_imem_uart_loader;
  localparam int CPB    = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
    int          addr;
    int          cnt;
    logic        isFull;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [ADDR_W-1:0] gotAddr[$];
  logic [31:0]       gotData[$];
  int                expAddr[$];
  logic [31:0]       expData[$];
  logic [7:0]        mBytes[$];
  int                mCnt = 0;
  logic              mErr = 1'b0;

  imem_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen between clock edges.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      gotAddr.push_back(bus.mem_addr);
      gotData.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame with a selectable stop bit, followed by an idle gap.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = frame[i];
      waitCycles(CPB);
    end
    bus.rx = 1'b1;
    waitCycles(6);
  endtask

  task automatic setLoad(input logic v);
    bus.load_en = v;
    waitCycles(6);
  endtask

  task automatic modelClear();
    mCnt = 0;
    mErr = 1'b0;
    mBytes.delete();
  endtask

  task automatic modelByte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      mErr = 1'b1;
      return;
    end
    mBytes.push_back(b);
    if (mBytes.size() == 4) begin
      if (mCnt < DEPTH) begin
        expAddr.push_back(mCnt);
        expData.push_back({mBytes[3], mBytes[2], mBytes[1], mBytes[0]});
        mCnt++;
      end
      mBytes.delete();
    end
  endtask

  task automatic sendModeled(input logic [7:0] b, input logic ok);
    applyStimulus(b, ok);
    modelByte(b, ok);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, " write count"}, gotAddr.size(), expAddr.size());
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checkOutput({tag, " write addr"}, 32'(gotAddr[i]), expAddr[i]);
      checkOutput({tag, " write data"}, gotData[i], expData[i]);
    end
    gotAddr.delete();
    gotData.delete();
    expAddr.delete();
    expData.delete();
  endtask

  task automatic checkModelState(input string tag);
    checkOutput({tag, " word_cnt"}, 32'(bus.word_cnt), mCnt);
    checkOutput({tag, " full"}, 32'(bus.full), (mCnt == DEPTH) ? 1 : 0);
    checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), (mCnt < DEPTH) ? mCnt : DEPTH - 1);
    checkOutput({tag, " frame_err"}, 32'(bus.frame_err), 32'(mErr));
  endtask

  initial begin
    vec_t vecs[4];
    int   lat;
    int   n;

    vecs[0] = '{8'h13, 8'h05, 8'h00, 8'h00, 32'h00000513, 0, 1, 1'b0};
    vecs[1] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef, 1, 2, 1'b0};
    vecs[2] = '{8'h00, 8'hff, 8'h00, 8'hff, 32'hff00ff00, 2, 3, 1'b0};
    vecs[3] = '{8'ha5, 8'h5a, 8'hc3, 8'h3c, 32'h3cc35aa5, 3, 4, 1'b1};

    bus.rx = 1'b1;
    bus.load_en = 1'b0;
    waitCycles(3);
    checkOutput("reset mem_we", 32'(bus.mem_we), 0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 0);
    checkOutput("reset cpu_rst", 32'(bus.cpu_rst), 1);
    checkOutput("reset word_cnt", 32'(bus.word_cnt), 0);
    checkOutput("reset full", 32'(bus.full), 0);
    checkOutput("reset frame_err", 32'(bus.frame_err), 0);
    rst = 1'b0;
    waitCycles(3);
    checkOutput("idle cpu_rst", 32'(bus.cpu_rst), 0);

    // Fill memory from the vector table, one word per record.
    setLoad(1'b1);
    checkOutput("load cpu_rst", 32'(bus.cpu_rst), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].b0, 1'b1);
      applyStimulus(vecs[i].b1, 1'b1);
      applyStimulus(vecs[i].b2, 1'b1);
      applyStimulus(vecs[i].b3, 1'b1);
      waitCycles(4);
      checkOutput("vec write count", gotAddr.size(), 1);
      if (gotAddr.size() > 0) begin
        checkOutput("vec addr", 32'(gotAddr[0]), vecs[i].addr);
        checkOutput("vec data", gotData[0], vecs[i].word);
      end
      checkOutput("vec word_cnt", 32'(bus.word_cnt), vecs[i].cnt);
      checkOutput("vec full", 32'(bus.full), 32'(vecs[i].isFull));
      checkOutput("vec cpu_rst", 32'(bus.cpu_rst), 1);
      gotAddr.delete();
      gotData.delete();
    end
    for (int i = 0; i < 4; i++) applyStimulus(8'h11 * 8'(i + 1), 1'b1);
    waitCycles(4);
    checkOutput("full extra writes", gotAddr.size(), 0);
    checkOutput("full mem_addr", 32'(bus.mem_addr), 3);
    checkOutput("full word_cnt", 32'(bus.word_cnt), 4);
    checkOutput("full wdata hold", bus.mem_wdata, 32'h3cc35aa5);
    gotAddr.delete();
    gotData.delete();

    // Bad stop bit is dropped and frame_err is sticky until the next load start.
    setLoad(1'b0);
    setLoad(1'b1);
    modelClear();
    checkModelState("restart");
    sendModeled(8'h77, 1'b0);
    sendModeled(8'h93, 1'b1);
    sendModeled(8'h00, 1'b1);
    sendModeled(8'h10, 1'b1);
    sendModeled(8'h00, 1'b1);
    waitCycles(4);
    checkWrites("framing");
    checkModelState("framing");
    setLoad(1'b0);
    mBytes.delete();
    checkOutput("frame_err after fall", 32'(bus.frame_err), 1);
    setLoad(1'b1);
    modelClear();
    checkOutput("frame_err after rise", 32'(bus.frame_err), 0);

    // A one-cycle low on rx is a glitch, not a start bit.
    bus.rx = 1'b0;
    waitCycles(1);
    bus.rx = 1'b1;
    waitCycles(12);
    checkOutput("glitch frame_err", 32'(bus.frame_err), 0);
    sendModeled(8'h01, 1'b1);
    sendModeled(8'h02, 1'b1);
    sendModeled(8'h03, 1'b1);
    sendModeled(8'h04, 1'b1);
    waitCycles(4);
    checkWrites("glitch");
    checkModelState("glitch");

    // Dropping load_en mid-word discards the partial word and releases the CPU.
    sendModeled(8'haa, 1'b1);
    sendModeled(8'hbb, 1'b1);
    bus.load_en = 1'b0;
    lat = 0;
    while (bus.cpu_rst !== 1'b0 && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("cpu_rst release latency ok", (lat <= 3) ? 1 : 0, 1);
    mBytes.delete();
    waitCycles(20);
    checkWrites("drop");
    checkModelState("drop hold");
    setLoad(1'b1);
    modelClear();
    sendModeled(8'h21, 1'b1);
    sendModeled(8'h43, 1'b1);
    sendModeled(8'h65, 1'b1);
    sendModeled(8'h87, 1'b1);
    waitCycles(4);
    checkWrites("reload");
    checkModelState("reload");

    // Asynchronous reset in the data bits of the third byte.
    sendModeled(8'hc0, 1'b1);
    sendModeled(8'hde, 1'b1);
    bus.rx = 1'b0;
    waitCycles(CPB);
    bus.rx = 1'b1;
    waitCycles(CPB * 2);
    rst = 1'b1;
    #1;
    checkOutput("rst mem_we", 32'(bus.mem_we), 0);
    checkOutput("rst mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("rst mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst word_cnt", 32'(bus.word_cnt), 0);
    checkOutput("rst cpu_rst", 32'(bus.cpu_rst), 1);
    waitCycles(2);
    rst = 1'b0;
    modelClear();
    expAddr.delete();
    expData.delete();
    waitCycles(60);
    checkWrites("post rst");
    sendModeled(8'h55, 1'b1);
    sendModeled(8'h66, 1'b1);
    sendModeled(8'h77, 1'b1);
    sendModeled(8'h88, 1'b1);
    waitCycles(4);
    checkWrites("after rst");
    checkModelState("after rst");

    // Random load sessions with occasional bad stop bits.
    for (int s = 0; s < 6; s++) begin
      setLoad(1'b0);
      mBytes.delete();
      setLoad(1'b1);
      modelClear();
      n = $urandom_range(4, 22);
      for (int k = 0; k < n; k++) begin
        sendModeled(8'($urandom), ($urandom_range(0, 7) != 0));
      end
      waitCycles(4);
      checkWrites("random");
      checkModelState("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
